// File: rtl/dot_product_accumulator.sv
// Accumulates VEC_LEN unsigned products into one saturating dot-product result
// and hands it downstream over a valid/ready handshake.
module dot_product_accumulator #(
  parameter int unsigned PROD_W  = 16,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned VEC_LEN = 8,
  localparam int unsigned CNT_W  = $clog2(VEC_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_in,
  output logic              prod_ready,
  input  logic              flush,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [ACC_W-1:0]  result,
  output logic [CNT_W-1:0]  result_count,
  output logic              sat_flag,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic               w_acc_en;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_next;
  logic               r_sat;
  logic               w_sat_next;
  logic [ACC_W:0]     w_sum;
  logic               w_beat;
  logic               w_enter_hold;
  logic [ACC_W-1:0]   r_result;
  logic [CNT_W-1:0]   r_result_count;

  assign prod_ready   = (r_state != S_HOLD) && !rst;
  assign result_valid = (r_state == S_HOLD);
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign result_count = r_result_count;
  assign sat_flag     = r_sat;

  assign w_beat       = prod_valid && prod_ready;
  assign w_sum        = {1'b0, r_acc} + (ACC_W+1)'(prod_in);
  assign w_enter_hold = (w_state_next == S_HOLD) && (r_state != S_HOLD);

  // Next-state and datapath update; zero products leave the accumulator clock-gated
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_acc_en     = 1'b0;
    w_count_next = r_count;
    w_sat_next   = r_sat;
    case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          w_acc_next   = ACC_W'(prod_in);
          w_acc_en     = 1'b1;
          w_count_next = CNT_ONE;
          w_sat_next   = 1'b0;
          w_state_next = ((CNT_LAST == CNT_ONE) || flush) ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_beat) begin
          w_acc_en = (prod_in != '0);
          if (w_sum[ACC_W]) begin
            w_acc_next = ACC_MAX;
            w_sat_next = 1'b1;
          end else begin
            w_acc_next = w_sum[ACC_W-1:0];
          end
          w_count_next = r_count + CNT_ONE;
          if ((w_count_next == CNT_LAST) || flush) begin
            w_state_next = S_HOLD;
          end
        end else if (flush) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (result_ready) begin
          w_state_next = S_IDLE;
          w_acc_next   = '0;
          w_acc_en     = 1'b1;
          w_count_next = '0;
          w_sat_next   = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, accumulator and result capture (result latched on HOLD entry only)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_sat          <= 1'b0;
      r_result       <= '0;
      r_result_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_sat   <= w_sat_next;
      if (w_acc_en) begin
        r_acc <= w_acc_next;
      end
      if (w_enter_hold) begin
        r_result       <= w_acc_next;
        r_result_count <= w_count_next;
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Bench for dot_product_accumulator: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level vector model.
module tb_dot_product_accumulator;

  localparam int unsigned PW  = 16;
  localparam int unsigned AW  = 24;
  localparam int unsigned VL  = 8;
  localparam int unsigned CW  = $clog2(VL + 1);
  localparam int unsigned AW2 = 17;
  localparam int unsigned VL2 = 4;
  localparam int unsigned CW2 = $clog2(VL2 + 1);
  localparam longint MAX1 = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          prod_valid, flush, result_ready;
  logic [PW-1:0] prod_in;
  logic          prod_ready, result_valid, sat_flag, busy;
  logic [AW-1:0] result;
  logic [CW-1:0] result_count;

  logic           p2_valid, p2_flush, r2_ready;
  logic [PW-1:0]  p2_in;
  logic           p2_ready, r2_valid, s2_flag, b2_busy;
  logic [AW2-1:0] r2_result;
  logic [CW2-1:0] r2_count;

  int n_vec = 0;
  int n_err = 0;

  // Vector model: beats of the open vector, and the result last presented
  int unsigned m_beats[$];
  bit          m_hold;
  longint      m_res;
  int unsigned m_rcnt;

  always #5 clk = ~clk;

  dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .VEC_LEN(VL)) u_dut (
    .clk(clk), .rst(rst), .prod_valid(prod_valid), .prod_in(prod_in),
    .prod_ready(prod_ready), .flush(flush), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .result_count(result_count),
    .sat_flag(sat_flag), .busy(busy)
  );

  dot_product_accumulator #(.PROD_W(PW), .ACC_W(AW2), .VEC_LEN(VL2)) u_sat (
    .clk(clk), .rst(rst), .prod_valid(p2_valid), .prod_in(p2_in),
    .prod_ready(p2_ready), .flush(p2_flush), .result_valid(r2_valid),
    .result_ready(r2_ready), .result(r2_result), .result_count(r2_count),
    .sat_flag(s2_flag), .busy(b2_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint m_sum();
    longint s = 0;
    foreach (m_beats[i]) s += longint'(m_beats[i]);
    return s;
  endfunction

  function automatic void m_clear_all();
    m_beats.delete();
    m_hold = 1'b0;
    m_res  = 0;
    m_rcnt = 0;
  endfunction

  // One cycle on the main DUT: apply inputs, check outputs, advance the model
  task automatic cyc(input logic v, input logic [PW-1:0] d, input logic f, input logic rr);
    longint s;
    prod_valid   = v;
    prod_in      = d;
    flush        = f;
    result_ready = rr;
    chk("result_valid", 64'(result_valid), 64'(m_hold));
    chk("prod_ready", 64'(prod_ready), 64'(!m_hold));
    chk("busy", 64'(busy), 64'(m_hold || (m_beats.size() != 0)));
    chk("result", 64'(result), 64'(m_res));
    chk("result_count", 64'(result_count), 64'(m_rcnt));
    chk("sat_flag", 64'(sat_flag), 64'(m_sum() > MAX1));
    if (m_hold) begin
      if (rr) begin
        m_hold = 1'b0;
        m_beats.delete();
      end
    end else begin
      if (v) m_beats.push_back(int'(d));
      if ((m_beats.size() != 0) && ((m_beats.size() == VL) || f)) begin
        m_hold = 1'b1;
        s      = m_sum();
        m_res  = (s > MAX1) ? MAX1 : s;
        m_rcnt = m_beats.size();
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [PW-1:0] mix [8];
    logic [PW-1:0] d;
    rst = 1'b1;
    prod_valid = 1'b0; prod_in = '0; flush = 1'b0; result_ready = 1'b0;
    p2_valid = 1'b0; p2_in = '0; p2_flush = 1'b0; r2_ready = 1'b1;
    m_clear_all();
    repeat (2) @(negedge clk);
    chk("rst_prod_ready", 64'(prod_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full vector, back-to-back
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h00D2, 1'b0, 1'b1);
    chk("t1_valid", 64'(result_valid), 64'd1);
    chk("t1_result", 64'(result), 64'h690);
    chk("t1_count", 64'(result_count), 64'd8);
    chk("t1_ready_low", 64'(prod_ready), 64'd0);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t1_one_cycle", 64'(result_valid), 64'd0);

    // Early flush with the second beat, then a stray flush in IDLE
    cyc(1'b1, 16'h00D2, 1'b0, 1'b1);
    cyc(1'b1, 16'h0018, 1'b1, 1'b1);
    chk("t2_result", 64'(result), 64'hEA);
    chk("t2_count", 64'(result_count), 64'd2);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("t2_idle_flush", 64'(result_valid), 64'd0);

    // Zero products mixed in
    mix = '{16'h0, 16'h0018, 16'h0, 16'h0, 16'h00D2, 16'h0, 16'h0, 16'h0};
    for (int i = 0; i < 8; i++) cyc(1'b1, mix[i], 1'b0, 1'b1);
    chk("t3_result", 64'(result), 64'hEA);
    chk("t3_count", 64'(result_count), 64'd8);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Backpressure with a beat waiting
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    repeat (5) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a vector
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h00D2, 1'b0, 1'b1);
    prod_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_prod_ready", 64'(prod_ready), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_count", 64'(result_count), 64'd0);
    chk("arst_sat", 64'(sat_flag), 64'd0);
    m_clear_all();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0018, 1'b0, 1'b1);
    chk("t6_result", 64'(result), 64'hC0);
    chk("t6_count", 64'(result_count), 64'd8);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);

    // Saturation on the narrow instance
    for (int i = 1; i <= 4; i++) begin
      p2_valid = 1'b1; p2_in = 16'hFFFF;
      @(negedge clk);
      if (i < 4) chk("sat_sticky", 64'(s2_flag), 64'((longint'(i) * 65535) > 131071));
    end
    p2_valid = 1'b0;
    chk("sat_valid", 64'(r2_valid), 64'd1);
    chk("sat_result", 64'(r2_result), 64'h1FFFF);
    chk("sat_count", 64'(r2_count), 64'd4);
    chk("sat_flag", 64'(s2_flag), 64'd1);
    @(negedge clk);
    chk("sat_clear", 64'(s2_flag), 64'd0);
    chk("sat_keep", 64'(r2_result), 64'h1FFFF);
    for (int i = 0; i < 4; i++) begin
      p2_valid = 1'b1; p2_in = 16'h0001;
      @(negedge clk);
    end
    p2_valid = 1'b0;
    chk("sat2_result", 64'(r2_result), 64'd4);
    chk("sat2_flag", 64'(s2_flag), 64'd0);
    chk("sat2_count", 64'(r2_count), 64'd4);
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      d = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      cyc(($urandom_range(0, 9) < 7), d, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 6));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
